// File: rtl/flow_control_unit_if.sv
// Control bundle produced by the flow CPU decoder and consumed by the datapath and VGA.
interface flow_control_unit_if;
  logic        program_counter_increment;
  logic [3:0]  alu_op;
  logic [15:0] alu_a_altern;
  logic [15:0] alu_b_altern;
  logic [3:0]  alu_a_select;
  logic [3:0]  alu_b_select;
  logic        alu_a_source;
  logic        alu_b_source;
  logic [3:0]  alu_out_select;
  logic [1:0]  alu_load_src;
  logic        alu_store_to_mem;
  logic        alu_store_to_stk;
  logic [3:0]  vga_color_select;
  logic [3:0]  vga_coord_select;
  logic        vga_plot;
  logic        vga_resetn;

  modport master (
    output program_counter_increment, alu_op, alu_a_altern, alu_b_altern, alu_a_select,
           alu_b_select, alu_a_source, alu_b_source, alu_out_select, alu_load_src,
           alu_store_to_mem, alu_store_to_stk, vga_color_select, vga_coord_select, vga_plot,
           vga_resetn
  );

  modport slave (
    input program_counter_increment, alu_op, alu_a_altern, alu_b_altern, alu_a_select,
          alu_b_select, alu_a_source, alu_b_source, alu_out_select, alu_load_src,
          alu_store_to_mem, alu_store_to_stk, vga_color_select, vga_coord_select, vga_plot,
          vga_resetn
  );
endinterface

// File: rtl/flow_control_unit.sv
// Instruction decoder and run/stop sequencer for the flow 16-bit CPU.
// Optional feature: define HALT_ON_ERROR_EN to stop on errored register operands.
module flow_control_unit (
  input  logic                clock,
  input  logic                reset,
  input  logic                user_clock,
  input  logic                switch_clock,
  input  logic                clock_lock,
  input  logic [15:0]         current_instruction,
  input  logic [15:0]         switches,
  input  logic [15:0]         zeroflag,
  input  logic [15:0]         signflag,
  input  logic [15:0]         overflow,
  input  logic [15:0]         errorbit,
  flow_control_unit_if.master ctrl
);

  typedef enum logic {StStopped, StRunning} state_e;

  state_e state_q, state_d;
  logic   user_clock_q;
  logic   running;
  logic   user_clock_rise;
  logic   halt;
  logic   unused_flags;

  logic [3:0] op, x, y, z;
  assign {op, x, y, z} = current_instruction;

  logic [3:0]  dec_alu_op;
  logic [15:0] dec_a_altern, dec_b_altern;
  logic [3:0]  dec_a_sel, dec_b_sel, dec_out_sel;
  logic        dec_a_src, dec_b_src;
  logic [1:0]  dec_load_src;
  logic        dec_st_mem, dec_st_stk;
  logic [3:0]  dec_color, dec_coord;
  logic        dec_plot, dec_vclr, dec_swcl, dec_taken;
  logic        uses_a, uses_b;

  assign running         = (state_q == StRunning);
  assign user_clock_rise = user_clock & ~user_clock_q;

  always_comb begin
    dec_alu_op   = 4'h0;
    dec_a_altern = 16'h0000;
    dec_b_altern = 16'h0000;
    dec_a_sel    = 4'h0;
    dec_b_sel    = 4'h0;
    dec_out_sel  = 4'h0;
    dec_a_src    = 1'b0;
    dec_b_src    = 1'b0;
    dec_load_src = 2'b00;
    dec_st_mem   = 1'b0;
    dec_st_stk   = 1'b0;
    dec_color    = 4'h0;
    dec_coord    = 4'h0;
    dec_plot     = 1'b0;
    dec_vclr     = 1'b0;
    dec_swcl     = 1'b0;
    dec_taken    = 1'b0;
    uses_a       = 1'b0;
    uses_b       = 1'b0;
    unique case (op)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC: begin
        dec_alu_op   = op;
        dec_out_sel  = x;
        dec_a_sel    = y;
        dec_b_sel    = z;
        dec_load_src = 2'b01;
        uses_a       = 1'b1;
        uses_b       = 1'b1;
      end
      4'hE: begin
        dec_alu_op   = 4'h1;
        dec_a_sel    = z;
        dec_b_altern = {12'h000, y};
        dec_b_src    = 1'b1;
        dec_out_sel  = z;
        dec_load_src = 2'b01;
        uses_a       = 1'b1;
      end
      4'hF: begin
        unique case (x[3:2])
          2'b00:   dec_taken = 1'b1;
          2'b01:   dec_taken = ~zeroflag[y];
          2'b10:   dec_taken = zeroflag[y];
          default: dec_taken = signflag[y];
        endcase
        dec_a_sel    = z;
        dec_b_sel    = y;
        dec_load_src = dec_taken ? 2'b01 : 2'b00;
        uses_a       = 1'b1;
        uses_b       = 1'b1;
      end
      4'h0: begin
        case (x)
          4'h1: begin
            dec_alu_op   = y;
            dec_a_altern = switches;
            dec_a_src    = 1'b1;
            dec_b_sel    = z;
            dec_out_sel  = z;
            dec_load_src = 2'b01;
            uses_b       = 1'b1;
          end
          4'h3: dec_swcl = 1'b1;
          4'h8: begin
            dec_color = y;
            dec_coord = z;
            dec_plot  = 1'b1;
          end
          4'h9: dec_vclr = 1'b1;
          4'hC: begin
            dec_a_sel   = y;
            dec_b_sel   = z;
            dec_out_sel = y;
            dec_st_mem  = 1'b1;
            uses_a      = 1'b1;
            uses_b      = 1'b1;
          end
          4'hD: begin
            dec_b_sel  = z;
            dec_st_stk = 1'b1;
            uses_b     = 1'b1;
          end
          4'hE: begin
            dec_a_sel    = y;
            dec_out_sel  = z;
            dec_load_src = 2'b10;
            uses_a       = 1'b1;
          end
          4'hF: begin
            dec_out_sel  = z;
            dec_load_src = 2'b11;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

`ifdef HALT_ON_ERROR_EN
  assign halt = running & ((uses_a & errorbit[dec_a_sel]) | (uses_b & errorbit[dec_b_sel]));
  assign unused_flags = ^overflow;
`else
  assign halt = 1'b0;
  assign unused_flags = ^{overflow, errorbit, uses_a, uses_b};
`endif

  // Register selects always decode so the datapath can preview operands while stopped.
  always_comb begin
    ctrl.alu_a_select              = dec_a_sel;
    ctrl.alu_b_select              = dec_b_sel;
    ctrl.alu_out_select            = dec_out_sel;
    ctrl.program_counter_increment = 1'b0;
    ctrl.alu_op                    = 4'h0;
    ctrl.alu_a_altern              = 16'h0000;
    ctrl.alu_b_altern              = 16'h0000;
    ctrl.alu_a_source              = 1'b0;
    ctrl.alu_b_source              = 1'b0;
    ctrl.alu_load_src              = 2'b00;
    ctrl.alu_store_to_mem          = 1'b0;
    ctrl.alu_store_to_stk          = 1'b0;
    ctrl.vga_color_select          = 4'h0;
    ctrl.vga_coord_select          = 4'h0;
    ctrl.vga_plot                  = 1'b0;
    ctrl.vga_resetn                = 1'b1;
    if (running) begin
      ctrl.alu_op           = dec_alu_op;
      ctrl.alu_a_altern     = dec_a_altern;
      ctrl.alu_b_altern     = dec_b_altern;
      ctrl.alu_a_source     = dec_a_src;
      ctrl.alu_b_source     = dec_b_src;
      ctrl.vga_color_select = dec_color;
      ctrl.vga_coord_select = dec_coord;
      ctrl.vga_resetn       = ~dec_vclr;
      if (!halt) begin
        ctrl.alu_load_src              = dec_load_src;
        ctrl.alu_store_to_mem          = dec_st_mem;
        ctrl.alu_store_to_stk          = dec_st_stk;
        ctrl.vga_plot                  = dec_plot;
        ctrl.program_counter_increment = ~dec_swcl & ~dec_taken;
      end
    end
  end

  // SWCL beats a simultaneous resume edge.
  always_comb begin
    state_d = state_q;
    if (dec_swcl || halt) begin
      state_d = StStopped;
    end else if (running && switch_clock) begin
      state_d = StStopped;
    end else if (user_clock_rise && !clock_lock) begin
      state_d = StRunning;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StStopped;
      user_clock_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      user_clock_q <= user_clock;
    end
  end

endmodule

// File: tb/tb_flow_control_unit.sv
// Bench for flow_control_unit: directed vector table, multi-cycle sequences, random vs model.
module tb_flow_control_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        user_clock = 1'b0;
  logic        switch_clock = 1'b0;
  logic        clock_lock = 1'b0;
  logic [15:0] current_instruction = 16'h0000;
  logic [15:0] switches = 16'h0000;
  logic [15:0] zeroflag = 16'h0000;
  logic [15:0] signflag = 16'h0000;
  logic [15:0] overflow = 16'h0000;
  logic [15:0] errorbit = 16'h0000;

  flow_control_unit_if ctrl ();

  flow_control_unit dut (
    .clock               (clock),
    .reset               (reset),
    .user_clock          (user_clock),
    .switch_clock        (switch_clock),
    .clock_lock          (clock_lock),
    .current_instruction (current_instruction),
    .switches            (switches),
    .zeroflag            (zeroflag),
    .signflag            (signflag),
    .overflow            (overflow),
    .errorbit            (errorbit),
    .ctrl                (ctrl)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        pc_inc;
    logic [3:0]  alu_op;
    logic [15:0] a_alt;
    logic [15:0] b_alt;
    logic [3:0]  a_sel;
    logic [3:0]  b_sel;
    logic        a_src;
    logic        b_src;
    logic [3:0]  out_sel;
    logic [1:0]  load;
    logic        st_mem;
    logic        st_stk;
    logic [3:0]  color;
    logic [3:0]  coord;
    logic        plot;
    logic        vresetn;
  } exp_t;

  typedef struct {
    string       name;
    logic [15:0] ins;
    logic [15:0] sw;
    logic [15:0] zf;
    logic        uc;
    logic        sc;
    exp_t        exp;
  } vec_t;

  int total = 0;
  int bad = 0;

  function automatic exp_t e(input logic pc, input logic [3:0] op, input logic [15:0] aalt,
                             input logic [15:0] balt, input logic [3:0] asel, bsel,
                             input logic asrc, bsrc, input logic [3:0] out,
                             input logic [1:0] load, input logic mem, stk);
    exp_t r;
    r = '0;
    r.pc_inc = pc; r.alu_op = op; r.a_alt = aalt; r.b_alt = balt;
    r.a_sel = asel; r.b_sel = bsel; r.a_src = asrc; r.b_src = bsrc;
    r.out_sel = out; r.load = load; r.st_mem = mem; r.st_stk = stk;
    r.vresetn = 1'b1;
    return r;
  endfunction

  function automatic exp_t sample_dut();
    exp_t a;
    a.pc_inc  = ctrl.program_counter_increment;
    a.alu_op  = ctrl.alu_op;
    a.a_alt   = ctrl.alu_a_altern;
    a.b_alt   = ctrl.alu_b_altern;
    a.a_sel   = ctrl.alu_a_select;
    a.b_sel   = ctrl.alu_b_select;
    a.a_src   = ctrl.alu_a_source;
    a.b_src   = ctrl.alu_b_source;
    a.out_sel = ctrl.alu_out_select;
    a.load    = ctrl.alu_load_src;
    a.st_mem  = ctrl.alu_store_to_mem;
    a.st_stk  = ctrl.alu_store_to_stk;
    a.color   = ctrl.vga_color_select;
    a.coord   = ctrl.vga_coord_select;
    a.plot    = ctrl.vga_plot;
    a.vresetn = ctrl.vga_resetn;
    return a;
  endfunction

  // Reference behaviour: what each instruction means, then masking when the machine is stopped.
  function automatic exp_t model(input logic [15:0] ins, sw, zf, sf, input bit run);
    exp_t m, keep;
    logic [3:0] op, x, y, z;
    bit taken;
    {op, x, y, z} = ins;
    m = '0;
    m.vresetn = 1'b1;
    taken = 0;
    if (op >= 4'h1 && op <= 4'hC) begin
      m.alu_op = op; m.out_sel = x; m.a_sel = y; m.b_sel = z; m.load = 2'b01;
    end else if (op == 4'hE) begin
      m.alu_op = 4'h1; m.a_sel = z; m.b_alt = {12'h000, y}; m.b_src = 1'b1;
      m.out_sel = z; m.load = 2'b01;
    end else if (op == 4'hF) begin
      case (x / 4)
        0: taken = 1;
        1: taken = !zf[y];
        2: taken = zf[y];
        default: taken = sf[y];
      endcase
      m.a_sel = z; m.b_sel = y;
      m.load = taken ? 2'b01 : 2'b00;
    end else if (op == 4'h0) begin
      case (x)
        4'h1: begin
          m.alu_op = y; m.a_alt = sw; m.a_src = 1'b1; m.b_sel = z; m.out_sel = z;
          m.load = 2'b01;
        end
        4'h8: begin m.color = y; m.coord = z; m.plot = 1'b1; end
        4'h9: m.vresetn = 1'b0;
        4'hC: begin m.a_sel = y; m.b_sel = z; m.out_sel = y; m.st_mem = 1'b1; end
        4'hD: begin m.b_sel = z; m.st_stk = 1'b1; end
        4'hE: begin m.a_sel = y; m.out_sel = z; m.load = 2'b10; end
        4'hF: begin m.out_sel = z; m.load = 2'b11; end
        default: ;
      endcase
    end
    m.pc_inc = !(op == 4'h0 && x == 4'h3) && !taken;
    if (!run) begin
      keep = '0;
      keep.a_sel = m.a_sel; keep.b_sel = m.b_sel; keep.out_sel = m.out_sel;
      keep.vresetn = 1'b1;
      m = keep;
    end
    return m;
  endfunction

  task automatic check(input string name, input exp_t want);
    exp_t got;
    got = sample_dut();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic drive(input logic [15:0] ins, sw, zf, input logic uc, sc);
    @(negedge clock);
    current_instruction = ins;
    switches = sw;
    zeroflag = zf;
    user_clock = uc;
    switch_clock = sc;
    #1;
  endtask

  vec_t vecs[15];
  int   pc_count;
  bit   run_m, uc_m;
  logic [15:0] ins;
  logic        uc_r, sc_r, cl_r;

  initial begin
    vecs[0]  = '{"reset_state",   16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0,
                 e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[1]  = '{"stopped_incr",  16'hE066, 16'h0000, 16'h0000, 1'b1, 1'b0,
                 e(0, 0, 0, 0, 6, 0, 0, 0, 6, 0, 0, 0)};
    vecs[2]  = '{"incr",          16'hE066, 16'h0000, 16'h0000, 1'b1, 1'b0,
                 e(1, 1, 0, 16'h0006, 6, 0, 0, 1, 6, 2'b01, 0, 0)};
    vecs[3]  = '{"swcl",          16'h0300, 16'h0000, 16'h0000, 1'b1, 1'b0,
                 e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[4]  = '{"stop_swtr",     16'h0105, 16'h1567, 16'h0000, 1'b0, 1'b0,
                 e(0, 0, 0, 0, 0, 5, 0, 0, 5, 0, 0, 0)};
    vecs[5]  = '{"stop_swtr_low", 16'h0105, 16'h1567, 16'h0000, 1'b0, 1'b0,
                 e(0, 0, 0, 0, 0, 5, 0, 0, 5, 0, 0, 0)};
    vecs[6]  = '{"resume_edge",   16'h0105, 16'h1567, 16'h0000, 1'b1, 1'b0,
                 e(0, 0, 0, 0, 0, 5, 0, 0, 5, 0, 0, 0)};
    vecs[7]  = '{"swtr",          16'h0105, 16'h1567, 16'h0000, 1'b1, 1'b0,
                 e(1, 0, 16'h1567, 0, 0, 5, 1, 0, 5, 2'b01, 0, 0)};
    vecs[8]  = '{"wmem",          16'h0C56, 16'h1567, 16'h0000, 1'b1, 1'b0,
                 e(1, 0, 0, 0, 5, 6, 0, 0, 5, 2'b00, 1, 0)};
    vecs[9]  = '{"jnz_taken",     16'hF457, 16'h0000, 16'h0000, 1'b1, 1'b0,
                 e(0, 0, 0, 0, 7, 5, 0, 0, 0, 2'b01, 0, 0)};
    vecs[10] = '{"jnz_not_taken", 16'hF457, 16'h0000, 16'h0020, 1'b1, 1'b0,
                 e(1, 0, 0, 0, 7, 5, 0, 0, 0, 2'b00, 0, 0)};
    vecs[11] = '{"arith",         16'h3123, 16'h0000, 16'h0000, 1'b1, 1'b0,
                 e(1, 3, 0, 0, 2, 3, 0, 0, 1, 2'b01, 0, 0)};
    vecs[12] = '{"step_exec",     16'h3123, 16'h0000, 16'h0000, 1'b1, 1'b1,
                 e(1, 3, 0, 0, 2, 3, 0, 0, 1, 2'b01, 0, 0)};
    vecs[13] = '{"step_stopped",  16'h3123, 16'h0000, 16'h0000, 1'b1, 1'b1,
                 e(0, 0, 0, 0, 2, 3, 0, 0, 1, 0, 0, 0)};
    vecs[14] = '{"step_low",      16'h3123, 16'h0000, 16'h0000, 1'b0, 1'b1,
                 e(0, 0, 0, 0, 2, 3, 0, 0, 1, 0, 0, 0)};

    repeat (2) @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].ins, vecs[i].sw, vecs[i].zf, vecs[i].uc, vecs[i].sc);
      check(vecs[i].name, vecs[i].exp);
    end

    // Single step: one user_clock pulse must yield exactly one PC increment.
    pc_count = 0;
    for (int i = 0; i < 6; i++) begin
      drive(16'h3123, 16'h0000, 16'h0000, (i == 0), 1'b1);
      if (ctrl.program_counter_increment === 1'b1) pc_count++;
    end
    total++;
    if (pc_count != 1) begin
      bad++;
      $display("FAIL step_pulse_count: got %0d want 1", pc_count);
    end

    // SWCL together with a resume edge keeps the machine stopped.
    drive(16'h0300, 16'h0000, 16'h0000, 1'b1, 1'b0);
    drive(16'h3123, 16'h0000, 16'h0000, 1'b1, 1'b0);
    check("swcl_beats_edge", e(0, 0, 0, 0, 2, 3, 0, 0, 1, 0, 0, 0));

    // Reset mid-run stops the machine on the next edge.
    drive(16'h3123, 16'h0000, 16'h0000, 1'b0, 1'b0);
    drive(16'h3123, 16'h0000, 16'h0000, 1'b1, 1'b0);
    drive(16'h3123, 16'h0000, 16'h0000, 1'b1, 1'b0);
    check("run_before_reset", e(1, 3, 0, 0, 2, 3, 0, 0, 1, 2'b01, 0, 0));
    reset = 1'b1;
    drive(16'h3123, 16'h0000, 16'h0000, 1'b1, 1'b0);
    reset = 1'b0;
    drive(16'h3123, 16'h0000, 16'h0000, 1'b1, 1'b0);
    check("stopped_after_reset", e(0, 0, 0, 0, 2, 3, 0, 0, 1, 0, 0, 0));

    // Random phase: start from a clean reset so the model state is known.
    reset = 1'b1;
    drive(16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    reset = 1'b0;
    run_m = 0;
    uc_m  = 1;
    uc_r  = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      ins = 16'($urandom);
      if ($urandom_range(2) == 0) ins[15:12] = 4'h0;
      if ($urandom_range(3) == 0) uc_r = ~uc_r;
      sc_r = ($urandom_range(7) == 0);
      cl_r = ($urandom_range(5) == 0);
      current_instruction = ins;
      switches   = 16'($urandom);
      zeroflag   = 16'($urandom);
      signflag   = 16'($urandom);
      overflow   = 16'($urandom);
      errorbit   = 16'($urandom);
      user_clock = uc_r;
      switch_clock = sc_r;
      clock_lock = cl_r;
      #1;
      check($sformatf("rand_%0d_%h", i, ins), model(ins, switches, zeroflag, signflag, run_m));
      if (ins[15:8] == 8'h03) run_m = 0;
      else if (run_m && sc_r) run_m = 0;
      else if (uc_r && !uc_m && !cl_r) run_m = 1;
      uc_m = uc_r;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
